// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared constants and port-index helpers for the five-port
//               router switch allocator.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NPORT     = 5;
    localparam int BUF_DEPTH = 4;

    localparam logic [2:0] PORT_NONE  = 3'd0;
    localparam logic [2:0] PORT_LOCAL = 3'd5;

    // Advance a port index by one, wrapping 5 back to 1.
    function automatic logic [2:0] port_inc(input logic [2:0] p);
        return (p >= PORT_LOCAL) ? 3'd1 : p + 3'd1;
    endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/rr_arbiter5.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter5
// Description : Combinational five-request round-robin picker. Scans the
//               request vector starting at ptr (1-based) and wraps 5 -> 1.
//               req[0] is input 1, ..., req[4] is input 5.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] winner,
    output logic       valid
);

    logic [7:0] w_req_pad;
    logic [3:0] w_idx;

    // Pad so every 3-bit index is in range; indices 5..7 never request.
    assign w_req_pad = {3'b000, req};

    // First requester found scanning ptr, ptr+1, ... with wrap.
    always_comb begin
        winner = PORT_NONE;
        valid  = 1'b0;
        w_idx  = 4'd0;
        for (int k = 0; k < NPORT; k++) begin
            w_idx = {1'b0, ptr} + 4'(k) - 4'd1;
            if (w_idx >= 4'(NPORT)) begin
                w_idx = w_idx - 4'(NPORT);
            end
            if (!valid && (w_idx < 4'(NPORT)) && w_req_pad[w_idx[2:0]]) begin
                valid  = 1'b1;
                winner = w_idx[2:0] + 3'd1;
            end
        end
    end

endmodule : rr_arbiter5
`default_nettype wire

// File: rtl/switch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : switch_arbiter
// Description : Round-robin switch allocator for the five-port router.
//               Per-output priority pointers, credit counters on the four
//               inter-router outputs, registered one-cycle grants and
//               per-output crossbar selects.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_arbiter
    import noc_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          RST,
    input  logic [PW-1:0] targ1,
    input  logic [PW-1:0] targ2,
    input  logic [PW-1:0] targ3,
    input  logic [PW-1:0] targ4,
    input  logic [PW-1:0] targ5,
    input  logic          cred1,
    input  logic          cred2,
    input  logic          cred3,
    input  logic          cred4,
    output logic          grant1,
    output logic          grant2,
    output logic          grant3,
    output logic          grant4,
    output logic          grant5,
    output logic [PW-1:0] sel1,
    output logic [PW-1:0] sel2,
    output logic [PW-1:0] sel3,
    output logic [PW-1:0] sel4,
    output logic [PW-1:0] sel5
);

    localparam int         c_NCRED = NPORT - 1;
    localparam logic [2:0] c_DEPTH = 3'(DEPTH);

    // Registered state and next-state values
    logic [NPORT-1:0] grant_q, grant_d;
    logic [PW-1:0]    sel_q   [NPORT];
    logic [PW-1:0]    sel_d   [NPORT];
    logic [2:0]       ptr_q   [NPORT];
    logic [2:0]       ptr_d   [NPORT];
    logic [2:0]       count_q [c_NCRED];
    logic [2:0]       count_d [c_NCRED];

    // Combinational helpers
    logic [PW-1:0]      w_targ [NPORT];
    logic [NPORT-1:0]   w_req  [NPORT];
    logic [2:0]         w_win  [NPORT];
    logic [NPORT-1:0]   w_vld;
    logic [NPORT-1:0]   w_gnt_out;
    logic [c_NCRED-1:0] w_cred;
    logic [c_NCRED-1:0] w_cred_eff;

    assign w_targ[0] = targ1;
    assign w_targ[1] = targ2;
    assign w_targ[2] = targ3;
    assign w_targ[3] = targ4;
    assign w_targ[4] = targ5;
    assign w_cred    = {cred4, cred3, cred2, cred1};

    // Request decode: input i asks for output j unless it holds a grant
    // right now (its targ may still be stale during the grant cycle).
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            w_req[j] = '0;
            for (int i = 0; i < NPORT; i++) begin
                w_req[j][i] = (w_targ[i] == PW'(j + 1)) && !grant_q[i];
            end
        end
    end

    // One round-robin picker per output port
    for (genvar j = 0; j < NPORT; j++) begin : g_arb
        rr_arbiter5 u_rr (
            .req    (w_req[j]),
            .ptr    (ptr_q[j]),
            .winner (w_win[j]),
            .valid  (w_vld[j])
        );
    end

    // Credit gate: inter-router outputs grant only with a free downstream
    // slot as seen by the registered count; local ejection is never limited.
    always_comb begin
        w_gnt_out = '0;
        for (int j = 0; j < c_NCRED; j++) begin
            w_gnt_out[j] = w_vld[j] && (count_q[j] < c_DEPTH);
        end
        w_gnt_out[NPORT-1] = w_vld[NPORT-1];
    end

    // Next grants, selects and pointers from the gated winners
    always_comb begin
        grant_d = '0;
        for (int j = 0; j < NPORT; j++) begin
            sel_d[j] = '0;
            ptr_d[j] = ptr_q[j];
            if (w_gnt_out[j]) begin
                sel_d[j] = PW'(w_win[j]);
                ptr_d[j] = port_inc(w_win[j]);
                for (int i = 0; i < NPORT; i++) begin
                    if (w_win[j] == 3'(i + 1)) begin
                        grant_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Credit counters: +1 per grant, -1 per credit unless already empty
    always_comb begin
        for (int j = 0; j < c_NCRED; j++) begin
            w_cred_eff[j] = w_cred[j] && (count_q[j] != 3'd0);
            count_d[j]    = count_q[j] + {2'b00, w_gnt_out[j]}
                                       - {2'b00, w_cred_eff[j]};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RST) begin
            grant_q <= '0;
            for (int j = 0; j < NPORT; j++) begin
                sel_q[j] <= '0;
                ptr_q[j] <= 3'd1;
            end
            for (int j = 0; j < c_NCRED; j++) begin
                count_q[j] <= 3'd0;
            end
        end else begin
            grant_q <= grant_d;
            for (int j = 0; j < NPORT; j++) begin
                sel_q[j] <= sel_d[j];
                ptr_q[j] <= ptr_d[j];
            end
            for (int j = 0; j < c_NCRED; j++) begin
                count_q[j] <= count_d[j];
            end
        end
    end

    assign grant1 = grant_q[0];
    assign grant2 = grant_q[1];
    assign grant3 = grant_q[2];
    assign grant4 = grant_q[3];
    assign grant5 = grant_q[4];
    assign sel1   = sel_q[0];
    assign sel2   = sel_q[1];
    assign sel3   = sel_q[2];
    assign sel4   = sel_q[3];
    assign sel5   = sel_q[4];

endmodule : switch_arbiter
`default_nettype wire

// File: tb/tb_switch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_arbiter
// Description : Scoreboard bench for switch_arbiter. Directed stimulus pushes
//               expected grant/sel vectors tagged with their cycle; a monitor
//               pops and compares whenever the DUT presents a grant or select.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_arbiter;

    typedef struct {
        int          cyc;
        logic [4:0]  g;
        logic [14:0] s;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST;
    logic [2:0] targ1, targ2, targ3, targ4, targ5;
    logic       cred1, cred2, cred3, cred4;
    logic       grant1, grant2, grant3, grant4, grant5;
    logic [2:0] sel1, sel2, sel3, sel4, sel5;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    exp_t q[$];

    logic [4:0]  g_bus;
    logic [14:0] s_bus;
    assign g_bus = {grant5, grant4, grant3, grant2, grant1};
    assign s_bus = {sel5, sel4, sel3, sel2, sel1};

    switch_arbiter #(.DEPTH(4), .PW(3)) dut (
        .clk(clk), .RST(RST),
        .targ1(targ1), .targ2(targ2), .targ3(targ3), .targ4(targ4), .targ5(targ5),
        .cred1(cred1), .cred2(cred2), .cred3(cred3), .cred4(cred4),
        .grant1(grant1), .grant2(grant2), .grant3(grant3), .grant4(grant4), .grant5(grant5),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4), .sel5(sel5)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle N is the interval after the N-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] sel_at(input int j, input logic [2:0] v);
        logic [14:0] r;
        r = 15'(v);
        return r << (3 * (j - 1));
    endfunction

    task automatic push(input int c, input logic [4:0] g, input logic [14:0] s);
        exp_t e;
        e.cyc = c;
        e.g   = g;
        e.s   = s;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every presented grant/sel against the queue head,
    // and flag expectations whose cycle passes with nothing presented.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((g_bus != 5'd0) || (s_bus != 15'd0)) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_grant cyc=%0d got grant=%b sel=%h expected none",
                             cyc, g_bus, s_bus);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ((e.cyc != cyc) || (e.g !== g_bus) || (e.s !== s_bus)) begin
                        failures++;
                        $display("FAIL grant_sel cyc=%0d got grant=%b sel=%h expected cyc=%0d grant=%b sel=%h",
                                 cyc, g_bus, s_bus, e.cyc, e.g, e.s);
                    end
                end
            end else if ((q.size() > 0) && (q[0].cyc <= cyc)) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_grant cyc=%0d got grant=%b sel=%h expected grant=%b sel=%h",
                         cyc, g_bus, s_bus, e.g, e.s);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end

    int c0, k, s, b, d, l, a;

    initial begin
        RST   = 1'b1;
        targ1 = 3'd1; targ2 = 3'd1; targ3 = 3'd1; targ4 = 3'd1; targ5 = 3'd1;
        cred1 = 1'b0; cred2 = 1'b0; cred3 = 1'b0; cred4 = 1'b0;

        // Reset held for two edges with every input requesting output 1
        tick;
        mon_en = 1'b1;
        chk("reset_grant_c1", int'(g_bus), 0);
        chk("reset_sel_c1",   int'(s_bus), 0);
        tick;
        chk("reset_grant_c2", int'(g_bus), 0);
        chk("reset_sel_c2",   int'(s_bus), 0);
        RST = 1'b0;
        c0 = cyc;
        chk("reset_count1", int'(dut.count_q[0]), 0);

        // Contention on output 1, stall at DEPTH, credit release
        push(c0 + 1, 5'b00001, sel_at(1, 3'd1));
        push(c0 + 2, 5'b00010, sel_at(1, 3'd2));
        push(c0 + 3, 5'b00100, sel_at(1, 3'd3));
        push(c0 + 4, 5'b01000, sel_at(1, 3'd4));
        tick;
        tick; targ1 = 3'd0;
        tick; targ2 = 3'd0;
        tick; targ3 = 3'd0;
        chk("contend_count1_full", int'(dut.count_q[0]), 4);
        tick; targ4 = 3'd0;
        tick; cred1 = 1'b1; k = cyc;
        chk("stall_count1", int'(dut.count_q[0]), 4);
        tick; cred1 = 1'b0;
        chk("credit_count1", int'(dut.count_q[0]), 3);
        push(k + 2, 5'b10000, sel_at(1, 3'd5));
        tick;
        chk("refill_count1", int'(dut.count_q[0]), 4);
        tick; targ5 = 3'd0;

        // Single request to output 3
        tick; s = cyc; targ2 = 3'd3;
        push(s + 1, 5'b00010, sel_at(3, 3'd2));
        tick;
        chk("single_count3", int'(dut.count_q[2]), 1);
        tick; targ2 = 3'd0;

        // Fill output 2 to 3, then grant + credit together, then drain
        tick; b = cyc; targ1 = 3'd2; targ2 = 3'd2; targ3 = 3'd2;
        push(b + 1, 5'b00001, sel_at(2, 3'd1));
        push(b + 2, 5'b00010, sel_at(2, 3'd2));
        push(b + 3, 5'b00100, sel_at(2, 3'd3));
        tick;
        tick; targ1 = 3'd0;
        tick; targ2 = 3'd0;
        tick; targ3 = 3'd0;
        chk("fill_count2", int'(dut.count_q[1]), 3);
        tick; d = cyc; targ4 = 3'd2; cred2 = 1'b1;
        push(d + 1, 5'b01000, sel_at(2, 3'd4));
        tick; cred2 = 1'b0;
        chk("grant_credit_count2", int'(dut.count_q[1]), 3);
        tick; targ4 = 3'd0; cred2 = 1'b1;
        tick;
        chk("drain_count2_a", int'(dut.count_q[1]), 2);
        tick;
        chk("drain_count2_b", int'(dut.count_q[1]), 1);
        tick;
        chk("drain_count2_c", int'(dut.count_q[1]), 0);
        tick; cred2 = 1'b0;
        chk("underflow_count2", int'(dut.count_q[1]), 0);

        // Local ejection: request held for 20 cycles, grant every other cycle
        tick; l = cyc; targ1 = 3'd5;
        for (int n = 0; n < 10; n++) begin
            push(l + 1 + 2 * n, 5'b00001, sel_at(5, 3'd1));
        end
        repeat (19) tick;
        tick; targ1 = 3'd0;

        // Bring output 1 to count 4 with pointer 3, then reset mid-operation
        tick; a = cyc; cred1 = 1'b1;
        tick; cred1 = 1'b0; targ2 = 3'd1;
        chk("pre_reset_count1_a", int'(dut.count_q[0]), 3);
        push(a + 2, 5'b00010, sel_at(1, 3'd2));
        tick;
        tick; targ2 = 3'd0;
        chk("pre_reset_count1_b", int'(dut.count_q[0]), 4);
        chk("pre_reset_ptr1", int'(dut.ptr_q[0]), 3);
        RST = 1'b1; targ1 = 3'd1; targ3 = 3'd1; targ4 = 3'd3;
        tick; RST = 1'b0;
        chk("post_reset_count1", int'(dut.count_q[0]), 0);
        chk("post_reset_count3", int'(dut.count_q[2]), 0);
        chk("post_reset_ptr1", int'(dut.ptr_q[0]), 1);
        push(a + 5, 5'b01001, sel_at(1, 3'd1) | sel_at(3, 3'd4));
        push(a + 6, 5'b00100, sel_at(1, 3'd3));
        tick;
        tick; targ1 = 3'd0; targ4 = 3'd0;
        tick; targ3 = 3'd0;

        repeat (4) tick;
        chk("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_switch_arbiter
`default_nettype wire

// File: doc/switch_arbiter.md
# switch_arbiter

Round-robin switch allocator for the five-port router. Each cycle it arbitrates the five input-port requests (`targ1`..`targ5`) among the five output ports. It tracks downstream buffer occupancy with credit counters for the four inter-router outputs and issues a one-cycle grant to each winning input. It also drives a per-output crossbar select, so it sits between the input buffers' route computation and the crossbar.

## Interface
- `DEPTH`, default 4: downstream buffer depth per inter-router output (outputs 1–4).
- `PW`, default 3: port-code width; 0 = no request, 1–5 = output port, 6–7 = no request.

- `clk`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `targ1`..`targ5`  in  PW  requested output of inputs 1..5; held until granted.
- `cred1`..`cred4`  in  1  credit return from downstream of outputs 1..4; one slot freed per pulse.
- `grant1`..`grant5`  out  1  input i won arbitration; registered, one-cycle pulse.
- `sel1`..`sel5`  out  PW  input index (1–5) driving output j this cycle; 0 = idle.

## Operation
- State per output j:
  - `ptr_j`: priority pointer, values 1–5.
  - Outputs 1–4 only: `count_j`, 3 bits, range 0..DEPTH.
- Eligible requesters of output j: inputs i where `targ_i == j` and `grant_i == 0` in the current cycle.
  - Masking a currently granted input prevents a double grant while the requester is still updating `targ_i`.
- Output j may grant only if `count_j < DEPTH`, evaluated on the current registered value.
  - A `cred_j` arriving in the same cycle does not enable a grant until the next cycle.
- Output 5 is local ejection: never credit-limited.
- Winner selection: first eligible input scanning `ptr_j`, `ptr_j+1`, … with wrap 5→1.
- On a grant at the next edge:
  - `grant_winner <= 1` and `sel_j <= winner`.
  - `ptr_j <= winner+1`, with 5 wrapping to 1.
- Without a grant: `ptr_j` holds and `sel_j <= 0`.
- An input can target only one output, so at most one grant per input per cycle.
- All grants not issued at an edge are 0 in the following cycle.
- Counter update, outputs 1–4: `count_j <= count_j + g_j - c_j`.
  - g_j = grant issued to output j at this edge.
  - c_j = `cred_j` gated by `count_j != 0`. A credit arriving at count 0 is ignored (no underflow).
  - Grant and credit at the same edge leave the count unchanged.
  - The count never exceeds DEPTH, by construction of the grant gate.
- Reset values: all grants 0, all `sel` 0, all counts 0, all pointers 1.
- Reset mid-operation:
  - Everything returns to reset values at the next edge.
  - Credits pending downstream are discarded; the surrounding router is reset together.

## Timing
- Latency: request visible in cycle N → `grant`/`sel` high in cycle N+1.
- `count_j` reflects that grant from cycle N+1.
- Requester handshake: hold `targ_i` until it sees `grant_i` high, then change or clear `targ_i` at the edge that ends the grant cycle.
  - Maximum rate is one grant per input every 2 cycles.
  - An output can grant every cycle when it alternates between different inputs.
- `sel_j` is valid only in the cycle alongside the corresponding grant. The crossbar transfers the flit in that cycle.
- Credit effect: `cred_j` in cycle N reduces `count_j` in N+1. A grant against the freed slot can issue at the edge ending cycle N+1.

## Structure
- Shared package `noc_pkg`:
  - `PORT_NONE = 0`, `PORT_LOCAL = 5`.
  - `NPORT = 5`, `BUF_DEPTH = 4`.
  - The wrap-increment function for port indices.
- Sub-module `rr_arbiter5`: purely combinational 5-request round-robin picker with inputs req[5] and ptr and outputs winner index and valid. Instantiated five times, one per output.
- Top level holds:
  - pointer registers;
  - credit counters;
  - grant/sel registers;
  - request decode.

## Test plan
- Reset: hold `RST=1` for 2 cycles with all `targ` set to 1.
  - All `grant`/`sel` stay 0 during reset.
  - Counts are 0 afterwards, and the first grant goes to input 1.
- Single request: `targ2=3` in cycle 0.
  - Cycle 1: `grant2=1`, `sel3=2`, `count3=1`.
  - Cycle 2: `grant2=0`, `sel3=0`.
- Contention and credit stall: all five inputs target output 1, each clearing `targ` after its grant, no credits.
  - Grants go to inputs 1, 2, 3, 4 on consecutive cycles; `count1` reaches 4.
  - Input 5 is then stalled.
  - `cred1` pulse in cycle K → `count1=3` in K+1 → `grant5` in K+2.
- Simultaneous grant and credit:
  - At `count2=3`, a grant plus `cred2` in the same edge leaves `count2=3`.
  - `cred2` at `count2=0` leaves the count at 0.
- Local output unbounded: `targ1=5` re-asserted after each grant for 20 cycles.
  - `grant1` toggles every other cycle; no stall.
- Mid-operation reset: `RST` pulsed while `count1=4` and `ptr1=3`.
  - Next cycle: counts 0, `ptr1=1`, `grant` and `sel` 0.
  - The next grant follows index order from input 1.
